alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares one instance of the pipeline `alu` between two requesters (requester 0: execute stage; requester 1: the address/compare helper path). Provides a valid/ready request port and a valid/ready response port per requester, arbitrates between simultaneous requests, and registers operands and result. The block is a three-state sequencer: one operation is in flight at a time, and the result is held until it is consumed.

## Interface
- `WIDTH`, 32, operand/result width; the ALU is instantiated at 32 bits, so only 32 is supported.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `req_valid[1:0]` input 2: per-requester request valid.
- `req_ready[1:0]` output 2: per-requester request accept.
- `req_a0`, `req_b0`, `req_a1`, `req_b1` input 32 each: operands for requester 0 and requester 1.
- `req_op0`, `req_op1` input 3 each: opcodes (000 add, 001 sub, 010 and, 011 or, 101 slt, 111 sll).
- `rsp_valid[1:0]` output 2: response valid; one-hot to the owner.
- `rsp_ready[1:0]` input 2: per-requester response accept.
- `rsp_result` output 32: registered ALU result.
- `rsp_zero` output 1: registered, set when `rsp_result == 0`.
- `rsp_err` output 1: opcode was 100 or 110.
- `busy` output 1: FSM not in IDLE.

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - The arbiter picks a winner among the asserted `req_valid` bits and drives `req_ready[winner]=1`.
  - On the accept edge: latch a, b, op and the owner id, then go to EXEC.
  - With no valid requests, stay in IDLE.
- EXEC:
  - The ALU is driven from the latched operands.
  - On the next edge: latch result, zero and err, then go to DONE.
- DONE:
  - `rsp_valid[owner]=1`. Outputs stay stable until `rsp_ready[owner]`; on that edge return to IDLE.
  - `rsp_ready` of the non-owner is ignored.
- `req_ready` is 0 in EXEC and DONE. A request held by the losing requester stays pending and must remain stable until accepted.
- Arbitration (round-robin build):
  - The pointer `last` records the most recent winner.
  - On a tie, the requester other than `last` wins.
  - `last` updates only on an accept edge.
- Arithmetic:
  - add/sub wrap modulo 2^32.
  - slt is signed: result 32'h1 if a < b, else 0.
  - sll shifts a left by b[4:0].
- Opcodes 100 and 110: result forced to 0, `rsp_zero=1`, `rsp_err=1`. The operation still completes normally.
- Reset values: state IDLE, `last`=1 (so requester 0 wins the first tie), `req_ready`=0, `rsp_valid`=0, `rsp_result`=0, `rsp_zero`=0, `rsp_err`=0, `busy`=0.
- Reset asserted mid-operation: the in-flight operation and its response are dropped. Outputs take reset values immediately (asynchronous).

## Timing
- `req_ready` is combinational from `req_valid` and state; no combinational path from `rsp_ready` to `req_ready`.
- Accept at edge E0 → `rsp_valid` high after edge E1. Latency is 2 cycles from accept to response.
- If `rsp_ready` is already high, the response is consumed at E2 and IDLE accepts again with `req_ready` high in the cycle after E2. Peak throughput is one operation per 3 cycles.
- A request deasserted before its accept edge is never executed.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin arbitration as described above.
- `ALU_ARB_RR_EN` undefined: fixed priority, requester 0 always wins ties, and the `last` register is not built. All other behaviour is identical.

## Test plan
- Reset then single request: requester 0 requests a=1, b=0x10, op=000. Required: `req_ready[0]=1` in the same cycle; `rsp_valid[0]=1` 2 cycles after accept; result 0x11, zero=0, err=0.
- Contention: both requesters valid with requester 0 sub(5,5) and requester 1 or(1,0x10), `rsp_ready` tied high.
  - Round-robin build: requester 0 served first (result 0, zero=1), then requester 1 (result 0x11). A third tie goes to requester 0.
  - Fixed-priority build: requester 0 wins every tie.
- Backpressure: and(0xF0F0, 0xFF00) with `rsp_ready` low for 4 cycles. Required: `rsp_valid` and result 0xF000 held stable; `req_ready` stays 0; response consumed on the first cycle `rsp_ready` is high.
- Signed slt and sll: slt(0xFFFFFFFF, 1) → 1; slt(1, 0xFFFFFFFF) → 0; sll(1, 0x24) → 0x10, shift amount b[4:0]=4.
- Illegal opcode: op=100 with a=7, b=3. Required: result 0, zero=1, err=1, normal DONE handshake.
- Reset mid-operation: assert `reset` while in EXEC. Required: `busy`, `rsp_valid` and `req_ready` drop to 0 immediately; no response is delivered; the next request completes normally.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester front end for a single 32-bit ALU: arbitrate, execute one op, hold the result until consumed.
// Define ALU_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [2:0]       req_op0,
  input  logic [2:0]       req_op1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid and payload must hold stable until that edge, and ready
  // never depends combinationally on the consumer side of the other port.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic             owner;
  logic             winner;
  logic [WIDTH-1:0] alu_y;
  logic             alu_err;

`ifdef ALU_ARB_RR_EN
  logic last;

  always_comb begin
    winner = ~req_valid[0];
    if (req_valid == 2'b11) winner = ~last;
  end
`else
  always_comb begin
    winner = ~req_valid[0];
  end
`endif

  // Reset gates ready so an asserted reset never looks like an accept.
  always_comb begin
    req_ready = 2'b00;
    if (state == IDLE && !reset) req_ready = {winner, ~winner} & req_valid;
  end

  always_comb begin
    alu_y   = '0;
    alu_err = 1'b0;
    case (op_q)
      3'b000:  alu_y = a_q + b_q;
      3'b001:  alu_y = a_q - b_q;
      3'b010:  alu_y = a_q & b_q;
      3'b011:  alu_y = a_q | b_q;
      3'b101:  alu_y = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      3'b111:  alu_y = a_q << b_q[4:0];
      default: alu_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= 3'b000;
      owner      <= 1'b0;
      rsp_valid  <= 2'b00;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
`ifdef ALU_ARB_RR_EN
      last       <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|req_ready) begin
            a_q   <= winner ? req_a1 : req_a0;
            b_q   <= winner ? req_b1 : req_b0;
            op_q  <= winner ? req_op1 : req_op0;
            owner <= winner;
`ifdef ALU_ARB_RR_EN
            last  <= winner;
`endif
            state <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_y;
          rsp_zero   <= (alu_y == '0);
          rsp_err    <= alu_err;
          rsp_valid  <= owner ? 2'b10 : 2'b01;
          state      <= DONE;
        end
        DONE: begin
          if (rsp_ready[owner]) begin
            rsp_valid <= 2'b00;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter; follows ALU_ARB_RR_EN to pick the expected tie winners.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [2:0]  req_op0, req_op1;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_err;
  logic        busy;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  alu_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_op0(req_op0), .req_op1(req_op1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    if (id == 0) begin
      req_a0 = a; req_b0 = b; req_op0 = op; req_valid[0] = 1'b1;
    end else begin
      req_a1 = a; req_b1 = b; req_op1 = op; req_valid[1] = 1'b1;
    end
  endtask

  // Issues one request, waits (bounded) for the response, captures it and consumes it.
  task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        output logic [31:0] res, output logic z, output logic e,
                        output logic [1:0] rv, output int lat);
    int wait_acc;
    @(negedge clk);
    rsp_ready = 2'b00;
    req_valid = 2'b00;
    set_req(id, a, b, op);
    #1;
    wait_acc = 0;
    while (req_ready[id] !== 1'b1 && wait_acc < 20) begin
      @(negedge clk); #1; wait_acc++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    lat = 1;
    while (rsp_valid === 2'b00 && lat < 20) begin
      @(posedge clk); @(negedge clk); lat++;
    end
    if (wait_acc != 0) lat = lat + 100;
    res = rsp_result; z = rsp_zero; e = rsp_err; rv = rsp_valid;
    rsp_ready[id] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 2'b00;
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0; req_op0 = '0; req_op1 = '0;
    @(negedge clk); #1;
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
    total++; if (rsp_result !== 32'h0 || rsp_zero !== 1'b0 || rsp_err !== 1'b0)
      begin bad++; $display("FAIL reset_rsp got=%h/%b/%b exp=0/0/0", rsp_result, rsp_zero, rsp_err); end
    total++; if (busy !== 1'b0 || dbg_state !== 2'd0)
      begin bad++; $display("FAIL reset_busy got=%b/%0d exp=0/0", busy, dbg_state); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single;
    @(negedge clk);
    set_req(0, 32'h1, 32'h10, 3'b000);
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL single_req_ready got=%b exp=01", req_ready); end
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    total++; if (busy !== 1'b1 || rsp_valid !== 2'b00 || req_ready !== 2'b00 || dbg_state !== 2'd1)
      begin bad++; $display("FAIL single_exec got=%b/%b/%b/%0d exp=1/00/00/1", busy, rsp_valid, req_ready, dbg_state); end
    @(posedge clk);
    @(negedge clk);
    total++; if (rsp_valid !== 2'b01 || dbg_state !== 2'd2)
      begin bad++; $display("FAIL single_rsp_valid got=%b/%0d exp=01/2", rsp_valid, dbg_state); end
    total++; if (rsp_result !== 32'h11 || rsp_zero !== 1'b0 || rsp_err !== 1'b0)
      begin bad++; $display("FAIL single_result got=%h/%b/%b exp=11/0/0", rsp_result, rsp_zero, rsp_err); end
    rsp_ready = 2'b01;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 2'b00;
    total++; if (rsp_valid !== 2'b00 || busy !== 1'b0)
      begin bad++; $display("FAIL single_consume got=%b/%b exp=00/0", rsp_valid, busy); end
  endtask

  task automatic test_contention;
    int          exp_w[3];
    logic [1:0]  m;
    logic [31:0] er;
`ifdef ALU_ARB_RR_EN
    exp_w = '{0, 1, 0};
`else
    exp_w = '{0, 0, 0};
`endif
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    set_req(0, 32'h5, 32'h5, 3'b001);
    set_req(1, 32'h1, 32'h10, 3'b011);
    rsp_ready = 2'b11;
    for (int k = 0; k < 3; k++) begin
      m  = (exp_w[k] == 0) ? 2'b01 : 2'b10;
      er = (exp_w[k] == 0) ? 32'h0 : 32'h11;
      #1;
      total++; if (req_ready !== m) begin bad++; $display("FAIL tie%0d_grant got=%b exp=%b", k, req_ready, m); end
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      total++; if (rsp_valid !== m || rsp_result !== er || rsp_zero !== (er == 32'h0))
        begin bad++; $display("FAIL tie%0d_rsp got=%b/%h/%b exp=%b/%h/%b", k, rsp_valid, rsp_result, rsp_zero, m, er, (er == 32'h0)); end
      @(posedge clk); @(negedge clk);
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    rsp_ready = 2'b00;
    set_req(0, 32'hF0F0, 32'hFF00, 3'b010);
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL bp_grant got=%b exp=01", req_ready); end
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    set_req(1, 32'h2, 32'h3, 3'b000);
    rsp_ready = 2'b10;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      total++; if (rsp_valid !== 2'b01 || rsp_result !== 32'hF000 || req_ready !== 2'b00)
        begin bad++; $display("FAIL bp_hold%0d got=%b/%h/%b exp=01/f000/00", i, rsp_valid, rsp_result, req_ready); end
      @(posedge clk);
    end
    @(negedge clk);
    rsp_ready = 2'b01;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 2'b00;
    #1;
    total++; if (rsp_valid !== 2'b00 || req_ready !== 2'b10)
      begin bad++; $display("FAIL bp_release got=%b/%b exp=00/10", rsp_valid, req_ready); end
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    @(posedge clk);
    @(negedge clk);
    total++; if (rsp_valid !== 2'b10 || rsp_result !== 32'h5)
      begin bad++; $display("FAIL bp_pending got=%b/%h exp=10/5", rsp_valid, rsp_result); end
    rsp_ready = 2'b10;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 2'b00;
  endtask

  task automatic test_alu_ops;
    logic [31:0] va[6] = '{32'hFFFFFFFF, 32'h1, 32'h1, 32'h0, 32'h7, 32'h7};
    logic [31:0] vb[6] = '{32'h1, 32'hFFFFFFFF, 32'h24, 32'h1, 32'h3, 32'h3};
    logic [2:0]  vo[6] = '{3'b101, 3'b101, 3'b111, 3'b001, 3'b100, 3'b110};
    logic [31:0] vr[6] = '{32'h1, 32'h0, 32'h10, 32'hFFFFFFFF, 32'h0, 32'h0};
    logic        ve[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] res;
    logic        z, e;
    logic [1:0]  rv, m;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      m = ((i % 2) == 0) ? 2'b01 : 2'b10;
      run_op(i % 2, va[i], vb[i], vo[i], res, z, e, rv, lat);
      total++; if (res !== vr[i] || z !== (vr[i] == 32'h0) || e !== ve[i])
        begin bad++; $display("FAIL op%0d_result got=%h/%b/%b exp=%h/%b/%b", i, res, z, e, vr[i], (vr[i] == 32'h0), ve[i]); end
      total++; if (rv !== m || lat != 2)
        begin bad++; $display("FAIL op%0d_handshake got=%b/lat%0d exp=%b/lat2", i, rv, lat, m); end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] res;
    logic        z, e;
    logic [1:0]  rv;
    int          lat;
    @(negedge clk);
    set_req(0, 32'h100, 32'h200, 3'b000);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || rsp_valid !== 2'b00 || req_ready !== 2'b00 || dbg_state !== 2'd0)
      begin bad++; $display("FAIL midreset_drop got=%b/%b/%b/%0d exp=0/00/00/0", busy, rsp_valid, req_ready, dbg_state); end
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      total++; if (rsp_valid !== 2'b00 || busy !== 1'b0)
        begin bad++; $display("FAIL midreset_quiet%0d got=%b/%b exp=00/0", i, rsp_valid, busy); end
    end
    run_op(1, 32'h40, 32'h2, 3'b111, res, z, e, rv, lat);
    total++; if (res !== 32'h100 || z !== 1'b0 || e !== 1'b0 || rv !== 2'b10 || lat != 2)
      begin bad++; $display("FAIL midreset_next got=%h/%b/%b/%b/lat%0d exp=100/0/0/10/lat2", res, z, e, rv, lat); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_alu_ops();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
